// File: rtl/filter_pkg.sv
// Shared definitions for the window filter: mode encodings, bus word indexing
// and the default pixel saturation limit.
package filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_BOX   = 2'b01,
        MODE_SOBEL = 2'b10,
        MODE_LAP   = 2'b11
    } mode_e;

    localparam int PIX_W_DEF = 8;
    localparam int SAT_MAX   = (1 << PIX_W_DEF) - 1;

    // Word (y, x) of a square window sits at this index on the flattened bus.
    function automatic int word_idx(input int y, input int x, input int ope_size = 3);
        return y * ope_size + x;
    endfunction

endpackage

// File: rtl/window_filter_op_abs_sat.sv
// Absolute value of a signed operand, saturated to an unsigned PIX_W-bit pixel.
module abs_sat #(
    parameter int W_IN  = 12,
    parameter int PIX_W = 8
) (
    input  logic signed [W_IN-1:0] value,
    output logic        [PIX_W-1:0] result
);

    logic [W_IN-1:0] mag_s;

    // Magnitude is taken unsigned so the most negative input still maps correctly.
    always_comb begin
        mag_s = value[W_IN-1] ? (~value + W_IN'(1)) : value;
        if (mag_s > {{(W_IN-PIX_W){1'b0}}, {PIX_W{1'b1}}}) begin
            result = {PIX_W{1'b1}};
        end else begin
            result = mag_s[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/window_filter_op.sv
// Three-stage multi-mode window filter (pass, box mean, Sobel, Laplacian).
// Build with WINDOW_FILTER_THRESH_EN to add a reflesh-loaded binarising threshold.
import filter_pkg::*;

module window_filter_op #(
    parameter int OPE_SIZE  = 3,
    parameter int PIX_W     = 8,
    parameter int BOX_SHIFT = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   reflesh,
    input  logic [1:0]                             mode_in,
`ifdef WINDOW_FILTER_THRESH_EN
    input  logic [PIX_W-1:0]                       thresh,
`endif
    input  logic [(PIX_W+1)*OPE_SIZE*OPE_SIZE-1:0] data_bus,
    output logic [PIX_W:0]                         out,
    output logic [31:0]                            pix_count
);

    localparam int N     = OPE_SIZE * OPE_SIZE;
    localparam int C     = OPE_SIZE / 2;
    localparam int W_S   = PIX_W + 4;
    localparam int ROW_W = PIX_W + $clog2(OPE_SIZE);
    localparam int SUM_W = PIX_W + $clog2(N);
    localparam logic [PIX_W-1:0] SAT_V = {PIX_W{1'b1}};

    mode_e                    mode_r;
    logic [PIX_W-1:0]         thresh_r;
    logic [PIX_W-1:0]         pix_s [OPE_SIZE][OPE_SIZE];
    logic signed [W_S-1:0]    nb_s [3][3];
    logic [ROW_W-1:0]         row_sum_s [OPE_SIZE];
    logic signed [W_S-1:0]    term_a_s, term_b_s, term_c_s, term_d_s;
    logic                     valid_in_s;
    logic                     unused_vld_s;

    logic                     vld1_r, vld2_r;
    logic signed [W_S-1:0]    term_a_r, term_b_r, term_c_r, term_d_r;
    logic [ROW_W-1:0]         row_r [OPE_SIZE];
    logic signed [W_S-1:0]    sum1_r, sum2_r;
    logic [SUM_W-1:0]         box_r, box_sum_s, box_sh_s;
    logic [PIX_W-1:0]         abs_a_s, abs_b_s, res_s, pix_out_s;
    logic [PIX_W:0]           grad_sum_s;

    assign valid_in_s = data_bus[word_idx(C, C, OPE_SIZE)*(PIX_W+1) + PIX_W];

    // Mode (and threshold) only change on a flush, so a frame is never mixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r   <= MODE_PASS;
            thresh_r <= '0;
        end else if (reflesh) begin
            mode_r   <= mode_e'(mode_in);
`ifdef WINDOW_FILTER_THRESH_EN
            thresh_r <= thresh;
`else
            thresh_r <= '0;
`endif
        end
    end

    // S1 combinational: unpack the window and form the per-mode signed terms.
    always_comb begin
        unused_vld_s = 1'b0;
        for (int y = 0; y < OPE_SIZE; y++) begin
            row_sum_s[y] = '0;
            for (int x = 0; x < OPE_SIZE; x++) begin
                pix_s[y][x]  = data_bus[word_idx(y, x, OPE_SIZE)*(PIX_W+1) +: PIX_W];
                unused_vld_s = unused_vld_s ^ data_bus[word_idx(y, x, OPE_SIZE)*(PIX_W+1) + PIX_W];
                row_sum_s[y] = row_sum_s[y] + ROW_W'(pix_s[y][x]);
            end
        end
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                nb_s[dy][dx] = $signed({4'b0000, pix_s[C-1+dy][C-1+dx]});
            end
        end
        term_a_s = '0;
        term_b_s = '0;
        term_c_s = '0;
        term_d_s = '0;
        case (mode_r)
            MODE_PASS: term_a_s = nb_s[1][1];
            MODE_BOX: term_a_s = '0;
            MODE_SOBEL: begin
                term_a_s = nb_s[0][2] + (nb_s[1][2] <<< 1) + nb_s[2][2];
                term_b_s = nb_s[0][0] + (nb_s[1][0] <<< 1) + nb_s[2][0];
                term_c_s = nb_s[2][0] + (nb_s[2][1] <<< 1) + nb_s[2][2];
                term_d_s = nb_s[0][0] + (nb_s[0][1] <<< 1) + nb_s[0][2];
            end
            MODE_LAP: begin
                term_a_s = nb_s[1][1] <<< 2;
                term_b_s = nb_s[0][1] + nb_s[2][1] + nb_s[1][0] + nb_s[1][2];
            end
            default: term_a_s = '0;
        endcase
    end

    // S2 combinational: the box total is folded from the registered row sums.
    always_comb begin
        box_sum_s = '0;
        for (int y = 0; y < OPE_SIZE; y++) begin
            box_sum_s = box_sum_s + SUM_W'(row_r[y]);
        end
    end

    abs_sat #(.W_IN(W_S), .PIX_W(PIX_W)) u_abs_a (.value(sum1_r), .result(abs_a_s));
    abs_sat #(.W_IN(W_S), .PIX_W(PIX_W)) u_abs_b (.value(sum2_r), .result(abs_b_s));

    assign box_sh_s   = box_r >> BOX_SHIFT;
    assign grad_sum_s = {1'b0, abs_a_s} + {1'b0, abs_b_s};

    // S3 combinational: pass/Sobel/Laplacian share the |a|+|b| path (b is 0 when unused).
    always_comb begin
        res_s = '0;
        case (mode_r)
            MODE_BOX: begin
                if (box_sh_s > {{(SUM_W-PIX_W){1'b0}}, SAT_V}) begin
                    res_s = SAT_V;
                end else begin
                    res_s = box_sh_s[PIX_W-1:0];
                end
            end
            MODE_PASS, MODE_SOBEL, MODE_LAP: begin
                if (grad_sum_s[PIX_W]) begin
                    res_s = SAT_V;
                end else begin
                    res_s = grad_sum_s[PIX_W-1:0];
                end
            end
            default: res_s = '0;
        endcase
`ifdef WINDOW_FILTER_THRESH_EN
        pix_out_s = (res_s >= thresh_r) ? SAT_V : {PIX_W{1'b0}};
`else
        pix_out_s = res_s;
`endif
    end

    // Pipeline registers; a flush clears every stage and drops the current input.
    always_ff @(posedge clk) begin
        if (rst || reflesh) begin
            vld1_r    <= 1'b0;
            term_a_r  <= '0;
            term_b_r  <= '0;
            term_c_r  <= '0;
            term_d_r  <= '0;
            for (int y = 0; y < OPE_SIZE; y++) begin
                row_r[y] <= '0;
            end
            vld2_r    <= 1'b0;
            sum1_r    <= '0;
            sum2_r    <= '0;
            box_r     <= '0;
            out       <= '0;
            pix_count <= 32'd0;
        end else begin
            vld1_r    <= valid_in_s;
            term_a_r  <= term_a_s;
            term_b_r  <= term_b_s;
            term_c_r  <= term_c_s;
            term_d_r  <= term_d_s;
            for (int y = 0; y < OPE_SIZE; y++) begin
                row_r[y] <= row_sum_s[y];
            end
            vld2_r    <= vld1_r;
            sum1_r    <= term_a_r - term_b_r;
            sum2_r    <= term_c_r - term_d_r;
            box_r     <= box_sum_s;
            out       <= {vld2_r, pix_out_s};
            pix_count <= pix_count + 32'(vld2_r);
        end
    end

    logic unused_thresh_s;
    assign unused_thresh_s = ^thresh_r;

endmodule
